// File: rtl/cpu6_trap_ctrl.sv
// cpu6_trap_ctrl
// Trap controller for the cpu6 core. It takes timer interrupts and ECALLs
// from the E stage and drains the pipeline through the request/acknowledge
// handshake. It then commits mepc/mcause and redirects fetch to mtvec.
// MRET redirects fetch to mepc without a drain.
// All outputs are registered and follow the FSM state.

module cpu6_trap_ctrl #(
    parameter int TMO_W     = 4,
    parameter bit MIE_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validE,
    input  logic [31:0] pcE,
    input  logic        ecallE,
    input  logic        mretE,
    input  logic        tmr_irq_r,
    input  logic        csr_mtie_r,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    input  logic        empty_pipeline_ackW,
    output logic        empty_pipeline_reqE,
    output logic        killE,
    output logic [31:0] excp_mepc,
    output logic        excp_mepc_ena,
    output logic [31:0] excp_mcause,
    output logic        trap_pcsrc,
    output logic [31:0] trap_pcnext,
    output logic        mie_r,
    output logic        drain_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_RELEASE,
        ST_MRET
    } state_t;

    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
    localparam logic [31:0] CAUSE_ECALL = 32'd11;
    localparam logic [31:0] CAUSE_MTI   = 32'h8000_0007;

    state_t           state;
    logic [31:0]      epc_r;
    logic [31:0]      cause_r;
    logic [TMO_W-1:0] tmo;
    logic [TMO_W-1:0] tmo_next;
    logic             irq_take;
    logic             ecall_take;
    logic             mret_take;

    assign irq_take   = tmr_irq_r & csr_mtie_r & mie_r;
    assign ecall_take = validE & ecallE;
    assign mret_take  = validE & mretE;
    assign tmo_next   = tmo + TMO_ONE;

    // Trap sequencing FSM. Outputs are loaded on the edge that enters each
    // state, so every output is a pure function of the registered state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= ST_IDLE;
            epc_r               <= '0;
            cause_r             <= '0;
            tmo                 <= '0;
            mie_r               <= MIE_RESET;
            drain_err           <= 1'b0;
            empty_pipeline_reqE <= 1'b0;
            killE               <= 1'b0;
            excp_mepc           <= '0;
            excp_mepc_ena       <= 1'b0;
            excp_mcause         <= '0;
            trap_pcsrc          <= 1'b0;
            trap_pcnext         <= '0;
        end else begin
            excp_mepc     <= '0;
            excp_mepc_ena <= 1'b0;
            excp_mcause   <= '0;
            trap_pcsrc    <= 1'b0;
            trap_pcnext   <= '0;

            case (state)
                ST_IDLE: begin
                    if (ecall_take || irq_take) begin
                        epc_r               <= pcE;
                        cause_r             <= ecall_take ? CAUSE_ECALL : CAUSE_MTI;
                        tmo                 <= '0;
                        state               <= ST_DRAIN;
                        empty_pipeline_reqE <= 1'b1;
                        killE               <= 1'b1;
                    end else if (mret_take) begin
                        state               <= ST_MRET;
                        empty_pipeline_reqE <= 1'b0;
                        killE               <= 1'b1;
                        trap_pcsrc          <= 1'b1;
                        trap_pcnext         <= {csr_mepc[31:2], 2'b00};
                    end else begin
                        empty_pipeline_reqE <= 1'b0;
                        killE               <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    tmo <= tmo_next;
                    if (empty_pipeline_ackW || (tmo_next == TMO_MAX)) begin
                        if (!empty_pipeline_ackW) begin
                            drain_err <= 1'b1;
                        end
                        state               <= ST_COMMIT;
                        empty_pipeline_reqE <= 1'b0;
                        killE               <= 1'b1;
                        excp_mepc_ena       <= 1'b1;
                        excp_mepc           <= epc_r;
                        excp_mcause         <= cause_r;
                        trap_pcsrc          <= 1'b1;
                        trap_pcnext         <= {csr_mtvec[31:2], 2'b00};
                    end else begin
                        empty_pipeline_reqE <= 1'b1;
                        killE               <= 1'b1;
                    end
                end

                ST_COMMIT: begin
                    mie_r               <= 1'b0;
                    state               <= ST_RELEASE;
                    empty_pipeline_reqE <= 1'b0;
                    killE               <= 1'b1;
                end

                ST_RELEASE: begin
                    // A lingering ack must fall before a new request can be
                    // issued, otherwise it would satisfy that request at once.
                    empty_pipeline_reqE <= 1'b0;
                    if (!empty_pipeline_ackW) begin
                        state <= ST_IDLE;
                        killE <= 1'b0;
                    end else begin
                        killE <= 1'b1;
                    end
                end

                ST_MRET: begin
                    mie_r               <= 1'b1;
                    state               <= ST_IDLE;
                    empty_pipeline_reqE <= 1'b0;
                    killE               <= 1'b0;
                end

                default: begin
                    state               <= ST_IDLE;
                    empty_pipeline_reqE <= 1'b0;
                    killE               <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// tb_cpu6_trap_ctrl
// Directed bench for the trap controller. The datapath ack is modelled as the
// request delayed by one clock. It can also be forced low or high to exercise
// the timeout and stale-ack paths.

module tb_cpu6_trap_ctrl;

    logic        clk;
    logic        reset;
    logic        validE;
    logic [31:0] pcE;
    logic        ecallE;
    logic        mretE;
    logic        tmr_irq_r;
    logic        csr_mtie_r;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        empty_pipeline_ackW;
    logic        empty_pipeline_reqE;
    logic        killE;
    logic [31:0] excp_mepc;
    logic        excp_mepc_ena;
    logic [31:0] excp_mcause;
    logic        trap_pcsrc;
    logic [31:0] trap_pcnext;
    logic        mie_r;
    logic        drain_err;

    logic ack_pipe;
    int   ack_mode;
    int   total;
    int   bad;

    cpu6_trap_ctrl #(
        .TMO_W(4),
        .MIE_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .validE(validE),
        .pcE(pcE),
        .ecallE(ecallE),
        .mretE(mretE),
        .tmr_irq_r(tmr_irq_r),
        .csr_mtie_r(csr_mtie_r),
        .csr_mtvec(csr_mtvec),
        .csr_mepc(csr_mepc),
        .empty_pipeline_ackW(empty_pipeline_ackW),
        .empty_pipeline_reqE(empty_pipeline_reqE),
        .killE(killE),
        .excp_mepc(excp_mepc),
        .excp_mepc_ena(excp_mepc_ena),
        .excp_mcause(excp_mcause),
        .trap_pcsrc(trap_pcsrc),
        .trap_pcnext(trap_pcnext),
        .mie_r(mie_r),
        .drain_err(drain_err)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath model: the ack is the request carried one stage further
    always @(posedge clk) begin
        ack_pipe <= empty_pipeline_reqE;
    end

    // Ack source selection: 0 follows the pipeline, 1 forces low, 2 forces high
    assign empty_pipeline_ackW = (ack_mode == 0) ? ack_pipe : (ack_mode == 2);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic ec,
                                 input logic mr, input logic irq, input logic mtie);
        validE     = v;
        pcE        = pc;
        ecallE     = ec;
        mretE      = mr;
        tmr_irq_r  = irq;
        csr_mtie_r = mtie;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " req"}, {31'd0, empty_pipeline_reqE}, 32'd0);
        checkOutput({tag, " kill"}, {31'd0, killE}, 32'd0);
        checkOutput({tag, " ena"}, {31'd0, excp_mepc_ena}, 32'd0);
        checkOutput({tag, " pcsrc"}, {31'd0, trap_pcsrc}, 32'd0);
        checkOutput({tag, " mepc"}, excp_mepc, 32'd0);
        checkOutput({tag, " mcause"}, excp_mcause, 32'd0);
        checkOutput({tag, " pcnext"}, trap_pcnext, 32'd0);
    endtask

    // Directed sequence
    initial begin
        total    = 0;
        bad      = 0;
        ack_mode = 0;
        ack_pipe = 1'b0;
        reset    = 1'b1;
        csr_mtvec = 32'h0000_0400;
        csr_mepc  = 32'h0000_0103;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        $display("[TB] reset state");
        checkIdleOutputs("rst");
        checkOutput("rst mie", {31'd0, mie_r}, 32'd1);
        checkOutput("rst drain_err", {31'd0, drain_err}, 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] timer interrupt");
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("irq drain1 req", {31'd0, empty_pipeline_reqE}, 32'd1);
        checkOutput("irq drain1 kill", {31'd0, killE}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("irq drain2 req", {31'd0, empty_pipeline_reqE}, 32'd1);
        checkOutput("irq drain2 ena", {31'd0, excp_mepc_ena}, 32'd0);
        tick();
        checkOutput("irq commit req", {31'd0, empty_pipeline_reqE}, 32'd0);
        checkOutput("irq commit ena", {31'd0, excp_mepc_ena}, 32'd1);
        checkOutput("irq commit mepc", excp_mepc, 32'h100);
        checkOutput("irq commit mcause", excp_mcause, 32'h8000_0007);
        checkOutput("irq commit pcsrc", {31'd0, trap_pcsrc}, 32'd1);
        checkOutput("irq commit pcnext", trap_pcnext, 32'h400);
        checkOutput("irq commit kill", {31'd0, killE}, 32'd1);
        tick();
        checkOutput("irq release ena", {31'd0, excp_mepc_ena}, 32'd0);
        checkOutput("irq release pcsrc", {31'd0, trap_pcsrc}, 32'd0);
        checkOutput("irq release kill", {31'd0, killE}, 32'd1);
        checkOutput("irq release mie", {31'd0, mie_r}, 32'd0);
        tick();
        checkOutput("irq idle kill", {31'd0, killE}, 32'd0);

        $display("[TB] mret");
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("mret pcsrc", {31'd0, trap_pcsrc}, 32'd1);
        checkOutput("mret pcnext", trap_pcnext, 32'h100);
        checkOutput("mret kill", {31'd0, killE}, 32'd1);
        checkOutput("mret req", {31'd0, empty_pipeline_reqE}, 32'd0);
        checkOutput("mret mie before", {31'd0, mie_r}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("mret after pcsrc", {31'd0, trap_pcsrc}, 32'd0);
        checkOutput("mret after req", {31'd0, empty_pipeline_reqE}, 32'd0);
        checkOutput("mret after kill", {31'd0, killE}, 32'd0);
        checkOutput("mret mie after", {31'd0, mie_r}, 32'd1);

        $display("[TB] ecall and interrupt together");
        applyStimulus(1'b1, 32'h2C, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("prio drain1 req", {31'd0, empty_pipeline_reqE}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("prio drain2 req", {31'd0, empty_pipeline_reqE}, 32'd1);
        tick();
        checkOutput("prio commit ena", {31'd0, excp_mepc_ena}, 32'd1);
        checkOutput("prio commit mcause", excp_mcause, 32'd11);
        checkOutput("prio commit mepc", excp_mepc, 32'h2C);
        tick();
        checkOutput("prio release mie", {31'd0, mie_r}, 32'd0);
        tick();
        tick();
        checkOutput("prio masked req", {31'd0, empty_pipeline_reqE}, 32'd0);
        checkOutput("prio masked kill", {31'd0, killE}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] drain timeout");
        ack_mode = 1;
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 15; i++) begin
            tick();
            checkOutput($sformatf("tmo drain%0d req", i), {31'd0, empty_pipeline_reqE}, 32'd1);
        end
        checkOutput("tmo pre err", {31'd0, drain_err}, 32'd0);
        tick();
        checkOutput("tmo commit ena", {31'd0, excp_mepc_ena}, 32'd1);
        checkOutput("tmo commit mepc", excp_mepc, 32'h200);
        checkOutput("tmo commit req", {31'd0, empty_pipeline_reqE}, 32'd0);
        checkOutput("tmo drain_err", {31'd0, drain_err}, 32'd1);
        tick();
        tick();
        checkOutput("tmo idle kill", {31'd0, killE}, 32'd0);
        ack_mode = 0;

        $display("[TB] stale ack");
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("stale commit ena", {31'd0, excp_mepc_ena}, 32'd1);
        ack_mode = 2;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("stale release%0d kill", i), {31'd0, killE}, 32'd1);
            checkOutput($sformatf("stale release%0d req", i), {31'd0, empty_pipeline_reqE}, 32'd0);
        end
        ack_mode = 0;
        tick();
        checkOutput("stale idle kill", {31'd0, killE}, 32'd0);
        applyStimulus(1'b1, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stale next drain1 req", {31'd0, empty_pipeline_reqE}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stale next drain2 req", {31'd0, empty_pipeline_reqE}, 32'd1);
        checkOutput("stale next drain2 ena", {31'd0, excp_mepc_ena}, 32'd0);
        tick();
        checkOutput("stale next commit ena", {31'd0, excp_mepc_ena}, 32'd1);
        checkOutput("stale next commit mepc", excp_mepc, 32'h304);
        checkOutput("sticky drain_err", {31'd0, drain_err}, 32'd1);
        tick();
        tick();

        $display("[TB] reset during drain");
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rstd drain req", {31'd0, empty_pipeline_reqE}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkIdleOutputs("rstd");
        checkOutput("rstd mie", {31'd0, mie_r}, 32'd1);
        checkOutput("rstd drain_err", {31'd0, drain_err}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("rstd post%0d ena", i), {31'd0, excp_mepc_ena}, 32'd0);
            checkOutput($sformatf("rstd post%0d req", i), {31'd0, empty_pipeline_reqE}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu6_trap_ctrl.md
# cpu6_trap_ctrl

Trap controller for the cpu6 core: the initiating side of the datapath's empty-pipeline request/acknowledge handshake and the sole producer of `excp_mepc`/`excp_mepc_ena`. On a machine timer interrupt or ECALL in E it freezes issue, requests a pipeline drain, waits for the W-stage acknowledge, commits mepc/mcause, and redirects fetch to mtvec. On MRET it redirects fetch to mepc. Sits beside the datapath and feeds the fetch PC mux.

## Interface
- `TMO_W`, 4: width of the drain watchdog counter; timeout is 2^TMO_W−1 cycles.
- `MIE_RESET`, 1: reset value of the internal global interrupt enable.
- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `validE` in 1: the instruction in E is valid.
- `pcE` in 32: PC of the instruction in E.
- `ecallE` in 1: ECALL decoded in E. Qualified by `validE`.
- `mretE` in 1: MRET decoded in E. Qualified by `validE`.
- `tmr_irq_r` in 1: timer interrupt pending.
- `csr_mtie_r` in 1: timer interrupt enable from the CSR file.
- `csr_mtvec` in 32: trap vector base.
- `csr_mepc` in 32: MRET return address.
- `empty_pipeline_ackW` in 1: drain acknowledge; this is the request delayed through EX/MEM/WB.
- `empty_pipeline_reqE` out 1: drain request.
- `killE` out 1: squash the E instruction and hold fetch. Upstream suppresses `regwrite`/`memwrite`/`csr` while this is high.
- `excp_mepc` out 32: value to write into mepc.
- `excp_mepc_ena` out 1: one-cycle mepc write strobe.
- `excp_mcause` out 32: cause value, valid when `excp_mepc_ena` is high.
- `trap_pcsrc` out 1: one-cycle fetch redirect.
- `trap_pcnext` out 32: redirect target.
- `mie_r` out 1: global interrupt enable.
- `drain_err` out 1: sticky flag, set when a drain times out.

## Operation
- `irq_take = tmr_irq_r & csr_mtie_r & mie_r`.
- `ecall_take = validE & ecallE`.
- `mret_take = validE & mretE`.
- Priority: `ecall_take` > `irq_take` > `mret_take`.
- FSM states: IDLE, DRAIN, COMMIT, RELEASE, MRET.
- IDLE:
  - On `ecall_take` or `irq_take`: `epc_r <= pcE`. `cause_r <= 32'd11` for ECALL, `32'h8000_0007` for the interrupt. `tmo <= 0`. Go to DRAIN.
  - Else on `mret_take`: go to MRET.
- DRAIN:
  - Outputs: `empty_pipeline_reqE=1`, `killE=1`.
  - `tmo` increments each cycle.
  - On `empty_pipeline_ackW==1`: go to COMMIT.
  - Else on `tmo` reaching all-ones: set `drain_err`, go to COMMIT.
- COMMIT (exactly one cycle):
  - Outputs: `excp_mepc_ena=1`, `excp_mepc=epc_r`, `excp_mcause=cause_r`, `trap_pcsrc=1`, `trap_pcnext={csr_mtvec[31:2],2'b00}`, `killE=1`, `empty_pipeline_reqE=0`.
  - `mie_r <= 0`. Go to RELEASE.
- RELEASE:
  - Output: `killE=1`.
  - Wait for `empty_pipeline_ackW==0`, then go to IDLE. This prevents a stale ack from satisfying the next request.
- MRET (exactly one cycle):
  - Outputs: `trap_pcsrc=1`, `trap_pcnext={csr_mepc[31:2],2'b00}`, `killE=1`.
  - `mie_r <= 1`. Go to IDLE. No drain is performed.
- Triggers that arrive outside IDLE are ignored. Level-sensitive interrupts are re-evaluated on return to IDLE.
- The interrupting instruction is not executed: mepc holds its PC so that MRET re-executes it. ECALL stores its own PC; software adds 4.

## Timing
- Reset values:
  - State IDLE, `mie_r=MIE_RESET`, `drain_err=0`.
  - Every other output 0, including `excp_mepc` and `excp_mcause`.
  - `epc_r`, `cause_r` and `tmo` are 0.
- `empty_pipeline_reqE`, `killE`, `excp_*` and `trap_*` are Moore outputs decoded from the registered state. Nothing combinational goes from inputs to outputs.
- Trap latency, with the datapath's half-cycle pipeline registers (ack follows req by 1 cycle):
  - Trigger sampled at edge N. DRAIN covers N..N+1.
  - Ack is seen at N+2, so COMMIT is cycle N+2 and `trap_pcsrc` pulses there.
  - RELEASE lasts at least one cycle. IDLE is reached no earlier than N+4.
- `empty_pipeline_reqE` is held high continuously from DRAIN entry until the ack is sampled or the timeout fires. It is never dropped early.
- `excp_mepc_ena` and `trap_pcsrc` are exactly one cycle wide.
- Asserting `reset` in any state forces IDLE immediately and clears all strobes. A pending `mepc` write is lost.

## Test plan
- Timer interrupt: `mie_r=1`, `csr_mtie_r=1`, `tmr_irq_r=1`, `pcE=0x100`, `csr_mtvec=0x400`, ack returns 1 cycle after req.
  - Required: req high 2 cycles; then one-cycle `excp_mepc_ena` with `excp_mepc=0x100`, `excp_mcause=0x80000007`, `trap_pcnext=0x400`; then `mie_r=0`.
- ECALL and interrupt in the same cycle: `pcE=0x2C`.
  - Required: `excp_mcause=11`, `excp_mepc=0x2C`; the interrupt is not taken afterwards because `mie_r=0`.
- MRET: `csr_mepc=0x103` (low bits set).
  - Required: one-cycle `trap_pcsrc` with `trap_pcnext=0x100`; `mie_r` goes 0→1; `empty_pipeline_reqE` stays 0 throughout.
- Drain timeout: ack held 0, `TMO_W=4`.
  - Required: COMMIT entered after 15 DRAIN cycles; `drain_err=1` and remains set through later traps until reset.
- Stale ack: ack held high for 3 cycles after COMMIT.
  - Required: the FSM stays in RELEASE with `killE=1` until ack falls; the next trap's DRAIN lasts the full 2 cycles.
- Reset during DRAIN.
  - Required: all outputs 0 immediately; `mie_r=MIE_RESET`; after reset release, no `excp_mepc_ena` pulse occurs.
